// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Instruction presented whenever no valid fetch result is available.
    localparam logic [15:0] DEFAULT_NOP = 16'h0800;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Backing instruction memory read bus: controller is master, memory is slave.
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_done;

    modport master (output mem_rd, mem_addr, input mem_data, mem_done);
    modport slave  (input mem_rd, mem_addr, output mem_data, mem_done);

endinterface

// File: rtl/fetch_timeout_cnt.sv
// Watchdog counter for an outstanding memory read; tc marks the last allowed cycle.
module fetch_timeout_cnt #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Count waited cycles, saturating at the terminal value.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: one-entry hit buffer in front of a multi-cycle
// instruction memory, with redirect flush, watchdog timeout and PC stall.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEFAULT_NOP),
    parameter int unsigned     TIMEOUT   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   instr_addr,
    input  logic                fetch_en,
    input  logic                flush,
    input  logic                halt,
    input  logic                inv,
    instr_fetch_ctrl_if.master  mem,
    output logic [DATA_W-1:0]   instr,
    output logic                instr_valid,
    output logic                stall,
    output logic                err
);

    fetch_state_t      state;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [DATA_W-1:0] buf_data;
    logic [ADDR_W-1:0] req_addr;
    logic              hit;
    logic              fetch_req;
    logic              tc;

    assign hit       = buf_valid && (buf_tag == instr_addr);
    assign fetch_req = fetch_en && !halt && !flush;

    // Counter idles at zero and runs across WAIT and DRAIN of one access.
    fetch_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .en  (state != IDLE),
        .tc  (tc)
    );

    // Hold the PC while a miss is being issued or a read is still outstanding.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = fetch_req && !instr_addr[0] && !hit;
            WAIT:    stall = !mem.mem_done;
            DRAIN:   stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Fetch FSM with registered memory strobe, instruction and pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            instr        <= NOP_INSTR;
            instr_valid  <= 1'b0;
            err          <= 1'b0;
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
            buf_valid    <= 1'b0;
            buf_tag      <= '0;
            buf_data     <= '0;
            req_addr     <= '0;
        end else begin
            instr_valid <= 1'b0;
            err         <= 1'b0;
            mem.mem_rd  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        if (instr_addr[0]) begin
                            instr       <= NOP_INSTR;
                            instr_valid <= 1'b1;
                            err         <= 1'b1;
                        end else if (hit) begin
                            instr       <= buf_data;
                            instr_valid <= 1'b1;
                        end else begin
                            mem.mem_rd   <= 1'b1;
                            mem.mem_addr <= instr_addr;
                            req_addr     <= instr_addr;
                            state        <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_done) begin
                        if (!flush) begin
                            buf_valid   <= 1'b1;
                            buf_tag     <= req_addr;
                            buf_data    <= mem.mem_data;
                            instr       <= mem.mem_data;
                            instr_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (tc) begin
                        // A simultaneous redirect suppresses the NOP delivery.
                        err <= 1'b1;
                        if (!flush) begin
                            instr       <= NOP_INSTR;
                            instr_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem.mem_done) begin
                        state <= IDLE;
                    end else if (tc) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Invalidate last so it overrides a fill on the same edge.
            if (inv) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Responder side of the PC/instruction-address interface. Takes the PC's instr_addr each cycle and returns the 16-bit instruction through a multi-cycle backing instruction memory. Holds a one-entry hit buffer and handles redirect flushes and a watchdog timeout. Generates the stall that drives the PC unit's pause_PC, so the PC holds while a fetch is outstanding.

Parameters:
ADDR_W, 16, instruction address width
DATA_W, 16, instruction width
NOP_INSTR, 16'h0800, instruction presented when no valid fetch is available
TIMEOUT, 32, maximum WAIT cycles without mem_done before an error is raised (must be ≥2)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-low reset; sampled only on rising clk edge
instr_addr  in  ADDR_W  fetch address from PC unit
fetch_en  in  1  fetch request valid this cycle
flush  in  1  redirect (pc_sel taken); discard any outstanding fetch
halt  in  1  processor halted; no new fetches
inv  in  1  invalidate hit buffer (instruction memory written)
mem_rd  out  1  one-cycle read strobe to backing memory
mem_addr  out  ADDR_W  backing memory read address
mem_data  in  DATA_W  backing memory read data, valid with mem_done
mem_done  in  1  backing memory read complete
instr  out  DATA_W  fetched instruction (registered)
instr_valid  out  1  instr valid this cycle (registered, one-cycle pulse per fetch)
stall  out  1  combinational; hold PC (drives pause_PC)
err  out  1  one-cycle pulse: misaligned address or timeout

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; instr=NOP_INSTR; instr_valid=0; err=0; mem_rd=0; mem_addr=0; buffer tag invalid; timeout counter=0. Reset overrides all other inputs, including an access in progress; a mem_done arriving after reset is ignored.
- States: IDLE, WAIT, DRAIN.
- hit = buf_valid && (buf_tag == instr_addr).
- IDLE:
  - halt=1 or fetch_en=0: instr_valid<=0, stall=0, stay.
  - flush=1: instr_valid<=0, stall=0, stay. The PC loads the target; the fetch happens next cycle.
  - instr_addr[0]=1: instr<=NOP_INSTR, instr_valid<=1, err<=1, stall=0, no memory access.
  - hit: instr<=buf_data, instr_valid<=1 next cycle, stall=0 (single-cycle latency).
  - miss: stall=1 this cycle; mem_rd<=1 for one cycle; mem_addr<=instr_addr; latch req_addr; counter<=0; go to WAIT.
- WAIT:
  - stall = ~mem_done. mem_rd=0.
  - mem_done=1 and flush=0: buf_data<=mem_data, buf_tag<=req_addr, buf_valid<=1, instr<=mem_data, instr_valid<=1, go to IDLE.
  - flush=1 without mem_done: go to DRAIN.
  - flush=1 with mem_done: discard the data (no buffer update, instr_valid=0), go to IDLE.
  - Counter increments every WAIT cycle. If counter reaches TIMEOUT-1 with no mem_done: err<=1, instr<=NOP_INSTR, instr_valid<=1, go to IDLE.
- DRAIN:
  - stall=1.
  - On mem_done: discard the data, go to IDLE.
  - Same timeout rule as WAIT, but without an instr_valid pulse.
- instr_valid and err are single-cycle pulses; instr keeps its last value otherwise.
- inv=1 clears buf_valid at the next edge. If inv coincides with a WAIT fill, inv wins and buf_valid=0.
- halt asserted during WAIT/DRAIN does not abort the access; it only blocks new fetches from IDLE.
- A mem_done in IDLE is ignored.
- All address comparisons are full ADDR_W bits.

Decomposition:
- Shared package (fetch_pkg): state encoding (IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2) and NOP_INSTR constant.
- One natural sub-module: fetch_timeout_cnt (clear/enable counter with terminal-count output), reused for WAIT and DRAIN.
- Hit buffer and FSM stay in the top module.

Test Plan:
- Reset, then fetch_en=1, instr_addr=16'h0010; mem_done 3 cycles after mem_rd with mem_data=16'hC123 -> mem_rd pulses once, mem_addr=16'h0010, stall=1 until the mem_done cycle, instr=16'hC123 and instr_valid=1 the next cycle.
- Refetch 16'h0010 -> stall=0, no mem_rd, instr=16'hC123 valid after 1 cycle. Then pulse inv and refetch -> miss, new mem_rd issued.
- Miss on 16'h0020, flush on WAIT cycle 1, mem_done 2 cycles later -> DRAIN, stall held, no instr_valid, no buffer update. The next fetch of 16'h0020 misses again.
- instr_addr=16'h0003 -> instr=16'h0800, instr_valid=1, err=1, no mem_rd.
- Miss with mem_done never asserted, TIMEOUT=32 -> err pulse and instr=NOP_INSTR valid exactly 32 cycles after entering WAIT; stall drops and state returns to IDLE.
- rst=0 asserted mid-WAIT -> all outputs at reset values next edge. A late mem_done is ignored and the buffer stays invalid.
